// File: rtl/stream_fifo_chan_if.sv
// rtl/stream_fifo_chan_if.sv - ap_fifo handshake bundle between a producer, the channel and a consumer
interface stream_fifo_chan_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_write;
    logic                  if_full_n;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_read;
    logic                  if_empty_n;

    // master: the cells around the channel; slave: the channel itself
    modport master (
        output if_din, if_write, if_read,
        input  if_full_n, if_dout, if_empty_n
    );

    modport slave (
        input  if_din, if_write, if_read,
        output if_full_n, if_dout, if_empty_n
    );
endinterface

// File: rtl/stream_fifo_chan.sv
// rtl/stream_fifo_chan.sv - first-word-fall-through FIFO channel with sticky protocol-violation flags
module stream_fifo_chan #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    stream_fifo_chan_if.slave     s_chan,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  err_ovf,
    output logic                  err_udf
);
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_ONE   = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_usedw;
    logic                  r_empty_n;
    logic                  r_full_n;
    logic                  r_err_ovf;
    logic                  r_err_udf;

    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [ADDR_WIDTH:0]   w_usedw_next;

    assign w_wr_en = s_chan.if_write & r_full_n;
    assign w_rd_en = s_chan.if_read  & r_empty_n;

    always_comb begin
        w_usedw_next = r_usedw;
        if (w_wr_en && !w_rd_en) begin
            w_usedw_next = r_usedw + LP_ONE;
        end else if (w_rd_en && !w_wr_en) begin
            w_usedw_next = r_usedw - LP_ONE;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally at ADDR_WIDTH bits
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_usedw   <= '0;
            r_empty_n <= 1'b0;
            r_full_n  <= 1'b1;
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_usedw   <= w_usedw_next;
            r_empty_n <= (w_usedw_next != '0);
            r_full_n  <= (w_usedw_next != LP_DEPTH);
            if (s_chan.if_write && !r_full_n) begin
                r_err_ovf <= 1'b1;
            end
            if (s_chan.if_read && !r_empty_n) begin
                r_err_udf <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; occupancy alone decides validity
    always_ff @(posedge ap_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= s_chan.if_din;
        end
    end

    assign s_chan.if_dout    = r_mem[r_rd_ptr];
    assign s_chan.if_empty_n = r_empty_n;
    assign s_chan.if_full_n  = r_full_n;
    assign usedw             = r_usedw;
    assign err_ovf           = r_err_ovf;
    assign err_udf           = r_err_udf;
endmodule

// File: tb/tb_stream_fifo_chan.sv
// tb/tb_stream_fifo_chan.sv - self-checking bench for stream_fifo_chan at DEPTH 2 and DEPTH 4
module tb_stream_fifo_chan;
    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    stream_fifo_chan_if #(.DATA_WIDTH(32)) f2 ();
    stream_fifo_chan_if #(.DATA_WIDTH(32)) f4 ();

    logic [1:0] usedw2;
    logic [2:0] usedw4;
    logic       ovf2, udf2, ovf4, udf4;

    stream_fifo_chan #(.DATA_WIDTH(32), .DEPTH(2), .ADDR_WIDTH(1)) dut2 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_chan(f2.slave),
        .usedw(usedw2), .err_ovf(ovf2), .err_udf(udf2)
    );
    stream_fifo_chan #(.DATA_WIDTH(32), .DEPTH(4), .ADDR_WIDTH(2)) dut4 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_chan(f4.slave),
        .usedw(usedw4), .err_ovf(ovf4), .err_udf(udf4)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] q2[$];
    logic [31:0] q4[$];
    logic [31:0] outs[$];
    bit m_ovf2, m_udf2, m_ovf4, m_udf4;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q2.delete(); q4.delete();
        m_ovf2 = 0; m_udf2 = 0; m_ovf4 = 0; m_udf4 = 0;
    endtask

    task automatic check2(input string tag);
        chk({tag, ".usedw"}, 64'(usedw2), 64'(q2.size()));
        chk({tag, ".empty_n"}, 64'(f2.if_empty_n), 64'(q2.size() != 0));
        chk({tag, ".full_n"}, 64'(f2.if_full_n), 64'(q2.size() != 2));
        chk({tag, ".ovf"}, 64'(ovf2), 64'(m_ovf2));
        chk({tag, ".udf"}, 64'(udf2), 64'(m_udf2));
        if (q2.size() != 0) chk({tag, ".dout"}, 64'(f2.if_dout), 64'(q2[0]));
    endtask

    task automatic check4(input string tag);
        chk({tag, ".usedw"}, 64'(usedw4), 64'(q4.size()));
        chk({tag, ".empty_n"}, 64'(f4.if_empty_n), 64'(q4.size() != 0));
        chk({tag, ".full_n"}, 64'(f4.if_full_n), 64'(q4.size() != 4));
        chk({tag, ".ovf"}, 64'(ovf4), 64'(m_ovf4));
        chk({tag, ".udf"}, 64'(udf4), 64'(m_udf4));
        if (q4.size() != 0) chk({tag, ".dout"}, 64'(f4.if_dout), 64'(q4[0]));
    endtask

    // One clock on the DEPTH=2 channel: drive at negedge, step model at posedge, sample at next negedge
    task automatic cyc2(input bit wr, input logic [31:0] din, input bit rd, input string tag);
        bit wok, rok;
        f2.if_write = wr; f2.if_din = din; f2.if_read = rd;
        wok = wr && (q2.size() < 2);
        rok = rd && (q2.size() > 0);
        if (wr && !wok) m_ovf2 = 1;
        if (rd && !rok) m_udf2 = 1;
        @(posedge ap_clk);
        if (rok) void'(q2.pop_front());
        if (wok) q2.push_back(din);
        @(negedge ap_clk);
        f2.if_write = 0; f2.if_read = 0;
        check2(tag);
    endtask

    task automatic cyc4(input bit wr, input logic [31:0] din, input bit rd, input bit chk_en);
        bit wok, rok;
        f4.if_write = wr; f4.if_din = din; f4.if_read = rd;
        wok = wr && (q4.size() < 4);
        rok = rd && (q4.size() > 0);
        if (wr && !wok) m_ovf4 = 1;
        if (rd && !rok) m_udf4 = 1;
        if (rok) outs.push_back(f4.if_dout);
        @(posedge ap_clk);
        if (rok) void'(q4.pop_front());
        if (wok) q4.push_back(din);
        @(negedge ap_clk);
        f4.if_write = 0; f4.if_read = 0;
        if (chk_en) check4("stream");
    endtask

    initial begin
        int next_val;
        int budget;
        f2.if_write = 0; f2.if_read = 0; f2.if_din = '0;
        f4.if_write = 0; f4.if_read = 0; f4.if_din = '0;
        model_reset();
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check2("reset2");
        check4("reset4");

        // Asynchronous reset in the middle of a clock period
        cyc2(1, 32'h1234, 0, "prefill");
        @(posedge ap_clk);
        #3 ap_rst_n = 1'b0;
        model_reset();
        #1 check2("async_rst");
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        cyc2(1, 32'h0000_0005, 0, "wr1");
        cyc2(1, 32'hFFFF_FFFE, 0, "wr2");
        cyc2(1, 32'h0000_0007, 1, "full_rw");
        cyc2(0, 32'h0, 1, "drain");
        cyc2(1, 32'h0000_002A, 1, "empty_rw");
        cyc2(0, 32'h0, 1, "pop_last");

        // Randomly stalled stream 1..16 through the DEPTH=4 channel
        outs.delete();
        next_val = 1;
        budget = 0;
        while (outs.size() < 16 && budget < 2000) begin
            bit wr, rd;
            wr = ($urandom_range(0, 2) != 0) && f4.if_full_n && (next_val <= 16);
            rd = ($urandom_range(0, 2) != 0) && f4.if_empty_n;
            cyc4(wr, 32'(next_val), rd, 1);
            if (wr) next_val++;
            budget++;
        end
        chk("stream_count", 64'(outs.size()), 64'd16);
        for (int i = 0; i < outs.size(); i++) begin
            chk($sformatf("stream_word%0d", i), 64'(outs[i]), 64'(i + 1));
        end
        chk("stream_ovf", 64'(ovf4), 64'd0);
        chk("stream_udf", 64'(udf4), 64'd0);

        // Reset with three words stored, then a fresh write
        cyc4(1, 32'hA1, 0, 0);
        cyc4(1, 32'hA2, 0, 0);
        cyc4(1, 32'hA3, 0, 0);
        check4("hold3");
        #2 ap_rst_n = 1'b0;
        model_reset();
        #2 ap_rst_n = 1'b1;
        check4("flushed");
        cyc4(1, 32'h9, 0, 0);
        check4("after_rst");
        chk("after_rst.dout9", 64'(f4.if_dout), 64'h9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
